cache_burst_server: RTL and testbench
=====================================

# cache_burst_server

Memory-side responder for the two-way instruction/data cache's fill interface. It accepts a cache-line read request (`sdram_req`, `sdram_rw`=1), fetches the eight 16-bit words of the line from a word-wide backend memory port, and streams them back on eight consecutive cycles. The first returned word is the critical word; `sdram_fill` marks that first cycle. It also services single-word writes with byte enables. It sits between the cache and the board memory controller or block-RAM model.

## Interface
Parameters:
- `ADDR_MSB`, 25, highest byte-address bit used; the word address is `addr[ADDR_MSB:1]`.
- `LINE_LOG2`, 3, log2 of words per line; the line is 8 words.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  32  cache byte address; sampled at request accept.
- `sdram_req`  in  1  cache request.
- `sdram_rw`  in  1  1 = line read, 0 = word write.
- `sdram_rwu` / `sdram_rwl`  in  1 each  active-low upper/lower byte write enables.
- `data_to_sdram`  in  16  write data from the cache.
- `data_from_sdram`  out  16  burst data to the cache.
- `sdram_fill`  out  1  one-cycle strobe on the first burst word.
- `wr_ack`  out  1  one-cycle write-complete pulse.
- `busy`  out  1  high from request accept to completion.
- `mem_addr`  out  `ADDR_MSB`  backend word address.
- `mem_rd` / `mem_wr`  out  1 each  backend read/write request, held until accepted.
- `mem_be`  out  2  active-high byte enables: bit 1 = upper byte, bit 0 = lower byte.
- `mem_wdata`  out  16  backend write data.
- `mem_busy`  in  1  backend stall; a request is accepted on any cycle where it is asserted and `mem_busy`=0.
- `mem_rvalid`  in  1  read data valid; returns arrive in issue order with arbitrary latency.
- `mem_rdata`  in  16  backend read data.

## Operation
- States: IDLE, ISSUE, COLLECT, STREAM, WRITE, REARM.
- IDLE, `sdram_req`=1:
  - Latch `addr`, `sdram_rw`, byte enables and data.
  - Latch `crit = addr[3:1]`.
  - Go to ISSUE if `sdram_rw`=1, otherwise to WRITE.
- ISSUE: issue 8 reads, issue index i = 0..7, at `mem_addr = {addr[ADDR_MSB:4], (crit+i) mod 8}`. The low 3 bits wrap within the line. The index advances only on acceptance. After the 8th accept, go to COLLECT.
- Read returns: count returns with `ret_ctr`, in both ISSUE and COLLECT. Each `mem_rvalid` writes `mem_rdata` into line-buffer slot `ret_ctr`. Returns beyond 8 are ignored.
- COLLECT: when `ret_ctr` reaches 8, go to STREAM. STREAM may start the cycle after the 8th return, even if that return landed in ISSUE.
- STREAM: 8 consecutive cycles, `data_from_sdram` = slot 0..7. `sdram_fill`=1 on slot 0 only. The cache captures one word per cycle without any further handshake, so the stream never stalls. Then go to REARM.
- WRITE:
  - Drive `mem_wr`, `mem_addr = addr[ADDR_MSB:1]`, `mem_be = {~rwu, ~rwl}`, `mem_wdata`.
  - On accept, pulse `wr_ack` for one cycle and go to REARM.
  - Both enables inactive (`mem_be`=00): skip `mem_wr`, pulse `wr_ack` the next cycle.
- REARM: wait for `sdram_req`=0, then go to IDLE. This prevents a held request from being serviced twice.
- `busy` = state ≠ IDLE and state ≠ REARM.
- Reset (any state):
  - Go to IDLE.
  - Clear counters.
  - All outputs drop to 0: `data_from_sdram`=0, `sdram_fill`=0, `wr_ack`=0, `busy`=0, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0.
  - Stale `mem_rvalid` pulses arriving in IDLE after reset are dropped.

## Timing
- All outputs are registered.
- Zero-wait backend with 1-cycle read latency: request sampled at edge 0 → ISSUE at cycle 1 → accepts at cycles 1..8 → returns at cycles 2..9 → `sdram_fill` at cycle 10 → last word at cycle 17.
- Write with zero-wait backend: `mem_wr` at cycle 1, `wr_ack` at cycle 2.
- `sdram_req` may drop at any time after accept without aborting the transaction.
- `mem_rd` and `mem_addr` are stable while `mem_busy`=1.

## Structure
- Shared package `cache_pkg`: `LINE_LOG2`, line word count, state enum, and fill/ack interface constants. The cache and this block both use it.
- Sub-module `line_buffer`: an 8×16 register file, 1 write port, 1 read port, combinational read.

## Test plan
- Read, `addr`=0x0000_1236 (crit=3), backend returns word w = 0x1000+w: `mem_addr` low bits go 3,4,5,6,7,0,1,2. Stream is 0x1003, 0x1004, 0x1005, 0x1006, 0x1007, 0x1000, 0x1001, 0x1002. `sdram_fill` is high only with 0x1003.
- Same read with `mem_busy` randomly high ~50% and read latency of 1–5 cycles: identical stream; the 8 stream cycles are contiguous.
- Byte write, `rwu`=0, `rwl`=1, data 0xABCD at 0x100: `mem_be`=10, `mem_wdata`=0xABCD, `wr_ack` pulses exactly once.
- `sdram_req` held high through completion: no second transaction until `req` drops; a new request afterwards is accepted.
- `reset` asserted mid-COLLECT after 4 returns, with 4 stale `mem_rvalid` pulses following: all outputs are 0 and there is no `sdram_fill`. The next read streams correct data.
- Both byte enables inactive: no `mem_wr`, `wr_ack` the cycle after WRITE entry.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared line geometry, fill-server states and request encodings
package cache_pkg;

  localparam int LINE_LOG2  = 3;
  localparam int LINE_WORDS = 1 << LINE_LOG2;
  localparam int WORD_W     = 16;

  localparam logic REQ_READ = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_COLLECT,
    S_STREAM,
    S_WRITE,
    S_REARM
  } burst_state_e;

  // Cache byte strobes are active-low; the backend wants active-high {upper, lower}.
  function automatic logic [1:0] byte_en(input logic rwu_n, input logic rwl_n);
    return {~rwu_n, ~rwl_n};
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one cache line of read-return storage, one write port, combinational read
module line_buffer import cache_pkg::*; #(
  parameter int DEPTH = LINE_WORDS,
  parameter int DW    = WORD_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cache_burst_server.sv
// rtl/cache_burst_server.sv - serves cache line fills (critical word first) and byte-masked word writes
module cache_burst_server #(
  parameter int ADDR_MSB  = 25,
  parameter int LINE_LOG2 = cache_pkg::LINE_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addr,
  input  logic                sdram_req,
  input  logic                sdram_rw,
  input  logic                sdram_rwu,
  input  logic                sdram_rwl,
  input  logic [15:0]         data_to_sdram,
  output logic [15:0]         data_from_sdram,
  output logic                sdram_fill,
  output logic                wr_ack,
  output logic                busy,
  output logic [ADDR_MSB-1:0] mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [1:0]          mem_be,
  output logic [15:0]         mem_wdata,
  input  logic                mem_busy,
  input  logic                mem_rvalid,
  input  logic [15:0]         mem_rdata
);
  import cache_pkg::*;

  localparam int WORDS = 1 << LINE_LOG2;
  localparam logic [LINE_LOG2:0]   RET_FULL = (LINE_LOG2 + 1)'(WORDS);
  localparam logic [LINE_LOG2-1:0] LAST_IDX = LINE_LOG2'(WORDS - 1);
  localparam logic [LINE_LOG2-1:0] IDX_ONE  = LINE_LOG2'(1);

  burst_state_e state_q, state_d;

  logic [LINE_LOG2-1:0] iss_q, iss_d;
  logic [LINE_LOG2:0]   ret_q, ret_d, ret_inc;
  logic [LINE_LOG2-1:0] str_q, str_d;
  logic [15:0]          data_q, data_d;
  logic                 fill_q, fill_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [ADDR_MSB-1:0]  maddr_q, maddr_d;
  logic [1:0]           be_q, be_d;
  logic [15:0]          wdata_q, wdata_d;

  logic                 rd_accept;
  logic                 buf_we;
  logic [LINE_LOG2-1:0] rd_idx;
  logic [15:0]          rd_data;
  logic [1:0]           req_be;
  logic                 addr_unused;

  assign addr_unused = ^{addr[31:ADDR_MSB+1], addr[0]};
  assign req_be      = byte_en(sdram_rwu, sdram_rwl);
  assign rd_accept   = rd_q & ~mem_busy;

  // Returns are counted in issue order, so slot 0 always holds the critical word.
  assign buf_we  = ((state_q == S_ISSUE) || (state_q == S_COLLECT)) && mem_rvalid && !ret_q[LINE_LOG2];
  assign ret_inc = ret_q + {{LINE_LOG2{1'b0}}, buf_we};
  assign rd_idx  = (state_q == S_STREAM) ? str_q + IDX_ONE : '0;

  line_buffer #(
    .DEPTH (WORDS),
    .DW    (16)
  ) u_line_buffer (
    .clk_i   (clk),
    .we_i    (buf_we),
    .waddr_i (ret_q[LINE_LOG2-1:0]),
    .wdata_i (mem_rdata),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sdram_req) state_d = (sdram_rw == REQ_READ) ? S_ISSUE : S_WRITE;
      S_ISSUE:   if (rd_accept && (iss_q == LAST_IDX)) state_d = S_COLLECT;
      S_COLLECT: if (ret_inc == RET_FULL) state_d = S_STREAM;
      S_STREAM:  if (str_q == LAST_IDX) state_d = S_REARM;
      S_WRITE:   if (!wr_q || !mem_busy) state_d = S_REARM;
      S_REARM:   if (!sdram_req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    iss_d   = iss_q;
    ret_d   = ret_inc;
    str_d   = '0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    maddr_d = maddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    fill_d  = 1'b0;
    data_d  = '0;
    busy_d  = (state_d != S_IDLE) && (state_d != S_REARM);
    case (state_q)
      S_IDLE: begin
        if (sdram_req) begin
          iss_d   = '0;
          ret_d   = '0;
          maddr_d = addr[ADDR_MSB:1];
          if (sdram_rw == REQ_READ) begin
            rd_d = 1'b1;
          end else begin
            be_d    = req_be;
            wdata_d = data_to_sdram;
            wr_d    = |req_be;
          end
        end
      end
      S_ISSUE: begin
        if (rd_accept) begin
          iss_d   = iss_q + IDX_ONE;
          maddr_d = {maddr_q[ADDR_MSB-1:LINE_LOG2], maddr_q[LINE_LOG2-1:0] + IDX_ONE};
          if (iss_q == LAST_IDX) rd_d = 1'b0;
        end
      end
      S_STREAM: str_d = str_q + IDX_ONE;
      S_WRITE: begin
        if (state_d == S_REARM) begin
          wr_d  = 1'b0;
          ack_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == S_STREAM) begin
      data_d = rd_data;
      fill_d = (state_q != S_STREAM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_q   <= '0;
      ret_q   <= '0;
      str_q   <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      maddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      str_q   <= str_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      maddr_q <= maddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign data_from_sdram = data_q;
  assign sdram_fill      = fill_q;
  assign wr_ack          = ack_q;
  assign busy            = busy_q;
  assign mem_addr        = maddr_q;
  assign mem_rd          = rd_q;
  assign mem_wr          = wr_q;
  assign mem_be          = be_q;
  assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_cache_burst_server.sv
// tb/tb_cache_burst_server.sv - directed self-checking bench for cache_burst_server
module tb_cache_burst_server;
  localparam int AMSB = 25;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     addr;
  logic            sdram_req, sdram_rw, sdram_rwu, sdram_rwl;
  logic [15:0]     data_to_sdram;
  logic [15:0]     data_from_sdram;
  logic            sdram_fill, wr_ack, busy;
  logic [AMSB-1:0] mem_addr;
  logic            mem_rd, mem_wr;
  logic [1:0]      mem_be;
  logic [15:0]     mem_wdata;
  logic            mem_busy, mem_rvalid;
  logic [15:0]     mem_rdata;

  cache_burst_server #(.ADDR_MSB(AMSB), .LINE_LOG2(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .addr            (addr),
    .sdram_req       (sdram_req),
    .sdram_rw        (sdram_rw),
    .sdram_rwu       (sdram_rwu),
    .sdram_rwl       (sdram_rwl),
    .data_to_sdram   (data_to_sdram),
    .data_from_sdram (data_from_sdram),
    .sdram_fill      (sdram_fill),
    .wr_ack          (wr_ack),
    .busy            (busy),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_busy        (mem_busy),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int lat_mode = 0;
  bit stall_en = 1'b0;
  int stale_req = 0, stale_done = 0;
  int flush_req = 0, flush_done = 0;
  int ret_t[$];
  logic [15:0] ret_v[$];
  int last_t = 0;
  logic [AMSB-1:0] addr_log[$];
  int wr_cnt = 0, stab_err = 0;
  int fill_cnt = 0, ack_cnt = 0;

  logic [15:0]     exp_s [8];
  logic [AMSB-1:0] exp_a [8];
  int wait_n;
  int wr_base, ack_base, fill_base;

  // Backend: in-order returns with selectable latency, optional random stalls.
  initial begin
    int lat, t;
    logic prev_rd, prev_busy;
    logic [AMSB-1:0] prev_addr;
    prev_rd = 1'b0; prev_busy = 1'b0; prev_addr = '0;
    mem_busy = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_rd && prev_busy && !reset && (mem_rd !== 1'b1 || mem_addr !== prev_addr)) stab_err++;
      if (flush_done != flush_req) begin
        ret_t.delete(); ret_v.delete(); flush_done = flush_req;
      end
      mem_rvalid = 1'b0; mem_rdata = 16'h0;
      if (stale_done != stale_req) begin
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD; stale_done++;
      end else if (ret_t.size() > 0 && ret_t[0] <= cyc) begin
        mem_rvalid = 1'b1; mem_rdata = ret_v.pop_front(); void'(ret_t.pop_front());
      end
      mem_busy = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mem_rd === 1'b1 && !mem_busy) begin
        lat = (lat_mode == 0) ? 1 : (lat_mode == 1) ? int'($urandom_range(1, 5)) : 8;
        t = cyc + lat;
        if (t <= last_t) t = last_t + 1;
        last_t = t;
        ret_t.push_back(t);
        ret_v.push_back(16'h1000 | {13'h0, mem_addr[2:0]});
        addr_log.push_back(mem_addr);
      end
      if (mem_wr === 1'b1 && !mem_busy) wr_cnt++;
      prev_rd = mem_rd; prev_busy = mem_busy; prev_addr = mem_addr;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sdram_fill === 1'b1) fill_cnt++;
      if (wr_ack === 1'b1) ack_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {data_from_sdram, sdram_fill, wr_ack, busy, mem_rd, mem_wr, mem_addr, mem_be, mem_wdata};
  endfunction

  task automatic wait_fill(input int limit);
    wait_n = 0;
    while (sdram_fill !== 1'b1 && wait_n < limit) begin
      @(negedge clk);
      wait_n++;
    end
    chk("fill_seen", 64'(sdram_fill), 64'd1);
  endtask

  task automatic stream_check(input string tag);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_data%0d", tag, k), 64'(data_from_sdram), 64'(exp_s[k]));
      chk($sformatf("%s_fill%0d", tag, k), 64'(sdram_fill), (k == 0) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    chk({tag, "_data_after"}, 64'(data_from_sdram), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic addr_check(input string tag);
    chk({tag, "_issue_count"}, 64'(addr_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(addr_log[i]), 64'(exp_a[i]));
    end
  endtask

  task automatic start_read(input logic [31:0] a);
    repeat (2) @(negedge clk);
    addr_log.delete();
    addr = a; sdram_rw = 1'b1; sdram_req = 1'b1;
    @(negedge clk);
    sdram_req = 1'b0; addr = 32'hFFFF_FFFF;
  endtask

  initial begin
    reset = 1'b1; addr = 32'h0; sdram_req = 1'b0; sdram_rw = 1'b0;
    sdram_rwu = 1'b1; sdram_rwl = 1'b1; data_to_sdram = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Zero-wait read, critical word 3
    exp_s = '{16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007, 16'h1000, 16'h1001, 16'h1002};
    exp_a = '{25'h91B, 25'h91C, 25'h91D, 25'h91E, 25'h91F, 25'h918, 25'h919, 25'h91A};
    repeat (2) @(negedge clk);
    addr_log.delete();
    addr = 32'h0000_1236; sdram_rw = 1'b1; sdram_req = 1'b1;
    @(negedge clk);
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_mem_rd", 64'(mem_rd), 64'd1);
    chk("rd_first_addr", 64'(mem_addr), 64'h91B);
    sdram_req = 1'b0; addr = 32'hFFFF_FFFF;
    wait_fill(60);
    chk("rd_fill_latency", 64'(wait_n + 1), 64'd10);
    stream_check("rd0");
    addr_check("rd0");

    // Same read with random stalls and 1..5 cycle latency
    stall_en = 1'b1; lat_mode = 1;
    start_read(32'h0000_1236);
    wait_fill(600);
    stream_check("rd_stall");
    addr_check("rd_stall");
    chk("rd_stall_stable", 64'(stab_err), 64'd0);
    stall_en = 1'b0; lat_mode = 0;

    // Upper-byte write with the request held through completion
    repeat (2) @(negedge clk);
    wr_base = wr_cnt; ack_base = ack_cnt;
    addr = 32'h0000_0100; sdram_rw = 1'b0; sdram_rwu = 1'b0; sdram_rwl = 1'b1;
    data_to_sdram = 16'hABCD; sdram_req = 1'b1;
    @(negedge clk);
    chk("wr_mem_wr", 64'(mem_wr), 64'd1);
    chk("wr_be", 64'(mem_be), 64'h2);
    chk("wr_wdata", 64'(mem_wdata), 64'hABCD);
    chk("wr_addr", 64'(mem_addr), 64'h80);
    chk("wr_ack_early", 64'(wr_ack), 64'd0);
    @(negedge clk);
    chk("wr_ack", 64'(wr_ack), 64'd1);
    chk("wr_mem_wr_drop", 64'(mem_wr), 64'd0);
    repeat (5) @(negedge clk);
    chk("held_ack_count", 64'(ack_cnt - ack_base), 64'd1);
    chk("held_wr_count", 64'(wr_cnt - wr_base), 64'd1);
    chk("held_busy", 64'(busy), 64'd0);
    sdram_req = 1'b0;
    @(negedge clk);

    // Both byte enables inactive: acknowledged without a backend write
    addr = 32'h0000_0200; sdram_rwu = 1'b1; sdram_rwl = 1'b1; data_to_sdram = 16'h5555;
    sdram_req = 1'b1;
    @(negedge clk);
    chk("nobe_accepted", 64'(busy), 64'd1);
    chk("nobe_mem_wr", 64'(mem_wr), 64'd0);
    chk("nobe_be", 64'(mem_be), 64'd0);
    chk("nobe_ack_early", 64'(wr_ack), 64'd0);
    @(negedge clk);
    chk("nobe_ack", 64'(wr_ack), 64'd1);
    sdram_req = 1'b0;
    @(negedge clk);
    chk("nobe_ack_pulse", 64'(wr_ack), 64'd0);
    chk("nobe_wr_count", 64'(wr_cnt - wr_base), 64'd1);

    // Reset in COLLECT after four returns, then stale returns in IDLE
    lat_mode = 2;
    start_read(32'h0000_1236);
    repeat (12) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    chk("pre_reset_rd_done", 64'(mem_rd), 64'd0);
    fill_base = fill_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", outs(), 64'h0);
    reset = 1'b0; flush_req++; stale_req += 4;
    repeat (8) @(negedge clk);
    chk("post_reset_outputs", outs(), 64'h0);
    chk("post_reset_no_fill", 64'(fill_cnt - fill_base), 64'd0);
    lat_mode = 0;

    // Read after reset, critical word 7
    exp_s = '{16'h1007, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006};
    exp_a = '{25'h1507, 25'h1500, 25'h1501, 25'h1502, 25'h1503, 25'h1504, 25'h1505, 25'h1506};
    start_read(32'h0000_2A0E);
    wait_fill(60);
    chk("rd7_fill_latency", 64'(wait_n + 1), 64'd10);
    stream_check("rd7");
    addr_check("rd7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
